source_scheduler: RTL and testbench

Time-multiplexing scheduler that shares the single FIFO write port (data_1 / data_1_en into the clock-domain-crossing wrapper) between the Fibonacci and timer producers. It is a drop-in replacement for the exclusive F-or-T control FSM in the top level. Both producers may be requested at once and are granted in round-robin quanta of QUANTUM accepted words. The block also handles FIFO backpressure and drains the buffer on stop.

---
 rtl/source_scheduler.sv | 176 +++++++++++++++++
 tb/tb_source_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/source_scheduler.sv
// Round-robin scheduler sharing one FIFO write port between the F and T producers.
// Optional per-source accepted-word counters are built when SCHED_STATS_EN is defined.
module source_scheduler #(
  parameter int WIDTH   = 16,
  parameter int QUANTUM = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_f,
  input  logic             start_t,
  input  logic             stop,
  input  logic             buffer_full,
  input  logic             buffer_empty,
  input  logic             data_2_valid,
  input  logic             f_valid,
  input  logic             t_valid,
  input  logic [WIDTH-1:0] f_data,
  input  logic [WIDTH-1:0] t_data,
  output logic             f_en,
  output logic             t_en,
  output logic             data_1_en,
  output logic [WIDTH-1:0] data_1,
  output logic [1:0]       modulo,
  output logic [5:0]       led,
  output logic [15:0]      f_words,
  output logic [15:0]      t_words
);

  localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN_F = 3'd1,
    RUN_T = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            req_f, req_f_nxt;
  logic            req_t, req_t_nxt;
  logic [QW-1:0]   q_cnt, q_cnt_nxt;
  logic            saved_t, saved_t_nxt;
  logic            q_last;

  assign q_last = (q_cnt == QW'(QUANTUM - 1));

  // State register: FSM state, request flags, turn counter and the grant parked during WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      req_f   <= 1'b0;
      req_t   <= 1'b0;
      q_cnt   <= '0;
      saved_t <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_f   <= req_f_nxt;
      req_t   <= req_t_nxt;
      q_cnt   <= q_cnt_nxt;
      saved_t <= saved_t_nxt;
    end
  end

  // Next-state logic; priority inside RUN is stop, then backpressure, then quantum switch.
  always_comb begin
    state_nxt   = state;
    req_f_nxt   = req_f;
    req_t_nxt   = req_t;
    q_cnt_nxt   = q_cnt;
    saved_t_nxt = saved_t;
    if (state != DRAIN) begin
      req_f_nxt = req_f | start_f;
      req_t_nxt = req_t | start_t;
    end
    case (state)
      IDLE: begin
        if (start_f) begin
          state_nxt = RUN_F;
          q_cnt_nxt = '0;
        end else if (start_t) begin
          state_nxt = RUN_T;
          q_cnt_nxt = '0;
        end
      end
      RUN_F, RUN_T: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else if (buffer_full) begin
          state_nxt   = WAIT;
          saved_t_nxt = (state == RUN_T);
        end else if (data_1_en) begin
          if (q_last) begin
            q_cnt_nxt = '0;
            if (state == RUN_F && req_t) begin
              state_nxt = RUN_T;
            end else if (state == RUN_T && req_f) begin
              state_nxt = RUN_F;
            end
          end else begin
            q_cnt_nxt = q_cnt + QW'(1);
          end
        end
      end
      WAIT: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else if (!buffer_full) begin
          state_nxt = saved_t ? RUN_T : RUN_F;
        end
      end
      DRAIN: begin
        if (buffer_empty && !data_2_valid) begin
          state_nxt = IDLE;
          req_f_nxt = 1'b0;
          req_t_nxt = 1'b0;
          q_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; only the write strobe and data look at the inputs.
  always_comb begin
    f_en      = (state == RUN_F);
    t_en      = (state == RUN_T);
    data_1_en = ((state == RUN_F && f_valid) || (state == RUN_T && t_valid)) && !buffer_full;
    data_1    = '0;
    if (data_1_en) begin
      data_1 = (state == RUN_F) ? f_data : t_data;
    end
    modulo = 2'b00;
    if (state == RUN_F || (state == WAIT && !saved_t)) begin
      modulo = 2'b10;
    end else if (state == RUN_T || (state == WAIT && saved_t)) begin
      modulo = 2'b01;
    end
    led    = 6'b000000;
    led[0] = (state == IDLE);
    led[1] = (state == RUN_F);
    led[2] = (state == RUN_T);
    led[3] = (state == WAIT);
    led[4] = (state == DRAIN);
    led[5] = req_f & req_t;
  end

`ifdef SCHED_STATS_EN
  logic [15:0] f_cnt, t_cnt;

  // Counters restart with every new session and stick at their maximum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      f_cnt <= '0;
      t_cnt <= '0;
    end else if (state == IDLE && (start_f || start_t)) begin
      f_cnt <= '0;
      t_cnt <= '0;
    end else begin
      if (data_1_en && state == RUN_F && f_cnt != 16'hFFFF) begin
        f_cnt <= f_cnt + 16'd1;
      end
      if (data_1_en && state == RUN_T && t_cnt != 16'hFFFF) begin
        t_cnt <= t_cnt + 16'd1;
      end
    end
  end

  assign f_words = f_cnt;
  assign t_words = t_cnt;
`else
  assign f_words = 16'd0;
  assign t_words = 16'd0;
`endif

endmodule

// File: tb/tb_source_scheduler.sv
// Bench for source_scheduler: directed scenarios plus randomized traffic against a session-level model.
module tb_source_scheduler;

  localparam int WIDTH   = 16;
  localparam int QUANTUM = 4;
`ifdef SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_WAIT  = 2;
  localparam int M_DRAIN = 3;

  localparam logic [26:0] RESET_OBS = {3'b000, 16'h0000, 2'b00, 6'b000001};

  logic             clk = 1'b0;
  logic             rst, start_f, start_t, stop;
  logic             buffer_full, buffer_empty, data_2_valid;
  logic             f_valid, t_valid;
  logic [WIDTH-1:0] f_data, t_data;
  logic             f_en, t_en, data_1_en;
  logic [WIDTH-1:0] data_1;
  logic [1:0]       modulo;
  logic [5:0]       led;
  logic [15:0]      f_words, t_words;
  logic [26:0]      obs;

  int cmps = 0;
  int errs = 0;

  // Session-level model: what is active, who owns the port, who is waiting for a turn.
  int m_mode, m_cnt, m_fw, m_tw;
  bit m_src, m_rf, m_rt;

  logic [WIDTH-1:0] exp_q[$];

  source_scheduler #(.WIDTH(WIDTH), .QUANTUM(QUANTUM)) dut (
    .clk(clk), .rst(rst), .start_f(start_f), .start_t(start_t), .stop(stop),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty), .data_2_valid(data_2_valid),
    .f_valid(f_valid), .t_valid(t_valid), .f_data(f_data), .t_data(t_data),
    .f_en(f_en), .t_en(t_en), .data_1_en(data_1_en), .data_1(data_1),
    .modulo(modulo), .led(led), .f_words(f_words), .t_words(t_words)
  );

  assign obs = {f_en, t_en, data_1_en, data_1, modulo, led};

  always #5 clk = ~clk;

  function automatic logic [26:0] model_out();
    logic fe, te, de;
    logic [WIDTH-1:0] d;
    logic [1:0] mo;
    logic [5:0] l;
    fe = (m_mode == M_RUN) && !m_src;
    te = (m_mode == M_RUN) && m_src;
    de = ((fe && f_valid) || (te && t_valid)) && !buffer_full;
    d  = de ? (fe ? f_data : t_data) : '0;
    mo = (m_mode == M_RUN || m_mode == M_WAIT) ? (m_src ? 2'b01 : 2'b10) : 2'b00;
    l  = '0;
    case (m_mode)
      M_IDLE:  l[0] = 1'b1;
      M_RUN:   l[m_src ? 2 : 1] = 1'b1;
      M_WAIT:  l[3] = 1'b1;
      default: l[4] = 1'b1;
    endcase
    l[5] = m_rf && m_rt;
    return {fe, te, de, d, mo, l};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_fw = 0; m_tw = 0;
    m_src = 1'b0; m_rf = 1'b0; m_rt = 1'b0;
  endtask

  task automatic model_step();
    bit acc, old_rf, old_rt;
    if (!rst) begin
      model_reset();
      return;
    end
    acc    = (m_mode == M_RUN) && (m_src ? t_valid : f_valid) && !buffer_full;
    old_rf = m_rf;
    old_rt = m_rt;
    if (m_mode != M_DRAIN) begin
      m_rf = m_rf | start_f;
      m_rt = m_rt | start_t;
    end
    if (acc && STATS) begin
      if (m_src) begin
        if (m_tw < 65535) m_tw++;
      end else begin
        if (m_fw < 65535) m_fw++;
      end
    end
    case (m_mode)
      M_IDLE: if (start_f || start_t) begin
        m_mode = M_RUN; m_src = !start_f; m_cnt = 0; m_fw = 0; m_tw = 0;
      end
      M_RUN: begin
        if (stop) m_mode = M_DRAIN;
        else if (buffer_full) m_mode = M_WAIT;
        else if (acc) begin
          if (m_cnt == QUANTUM - 1) begin
            m_cnt = 0;
            if (m_src ? old_rf : old_rt) m_src = !m_src;
          end else begin
            m_cnt++;
          end
        end
      end
      M_WAIT: begin
        if (stop) m_mode = M_DRAIN;
        else if (!buffer_full) m_mode = M_RUN;
      end
      default: if (buffer_empty && !data_2_valid) begin
        m_mode = M_IDLE; m_rf = 1'b0; m_rt = 1'b0; m_cnt = 0;
      end
    endcase
  endtask

  // Clock/advance: DUT and model both take the edge, then settle mid-low-phase.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_f = 0; start_t = 0; stop = 0; buffer_full = 0; buffer_empty = 0;
    data_2_valid = 0; f_valid = 0; t_valid = 0; f_data = '0; t_data = '0;
  endtask

  task automatic go_idle();
    clear_inputs();
    stop = 1; tick();
    stop = 0; buffer_empty = 1; tick();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0; start_f = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmps++;
      if (obs !== RESET_OBS) begin
        $display("FAIL reset cyc%0d got %h exp %h", i, obs, RESET_OBS); errs++;
      end
      cmps++;
      if ({f_words, t_words} !== 32'd0) begin
        $display("FAIL reset_stats got %h exp 0", {f_words, t_words}); errs++;
      end
    end
    rst = 1; start_f = 0; #1;
    cmps++;
    if (obs !== model_out()) begin
      $display("FAIL reset_release got %h exp %h", obs, model_out()); errs++;
    end
    tick();
  endtask

  task automatic test_single_source();
    int writes = 0;
    clear_inputs();
    start_t = 1; t_valid = 1; #1;
    cmps++;
    if (obs !== model_out()) begin
      $display("FAIL single_start got %h exp %h", obs, model_out()); errs++;
    end
    tick();
    start_t = 0;
    for (int i = 0; i < 10; i++) begin
      t_data = WIDTH'($urandom); f_data = WIDTH'($urandom);
      f_valid = 1'($urandom_range(0, 1)); #1;
      cmps++;
      if (obs !== model_out()) begin
        $display("FAIL single cyc%0d got %h exp %h", i, obs, model_out()); errs++;
      end
      cmps++;
      if (f_en !== 1'b0 || t_en !== 1'b1 || data_1_en !== 1'b1 || data_1 !== t_data) begin
        $display("FAIL single_write cyc%0d got en=%b%b we=%b d=%h exp en=01 we=1 d=%h",
                 i, f_en, t_en, data_1_en, data_1, t_data); errs++;
      end
      if (data_1_en === 1'b1) writes++;
      tick();
    end
    cmps++;
    if (writes != 10) begin
      $display("FAIL single_count got %0d exp 10", writes); errs++;
    end
    go_idle();
  endtask

  task automatic test_round_robin();
    clear_inputs();
    exp_q.delete();
    for (int k = 0; k < 12; k++) exp_q.push_back((k / QUANTUM) % 2 == 0 ? 16'h0F0F : 16'hA5A5);
    start_f = 1; start_t = 1; f_valid = 1; t_valid = 1;
    f_data = 16'h0F0F; t_data = 16'hA5A5;
    tick();
    start_f = 0; start_t = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      cmps++;
      if (obs !== model_out()) begin
        $display("FAIL rr cyc%0d got %h exp %h", i, obs, model_out()); errs++;
      end
      cmps++;
      if ((f_en & t_en) !== 1'b0 || led[5] !== 1'b1) begin
        $display("FAIL rr_flags cyc%0d got both_en=%b led5=%b exp 0/1", i, f_en & t_en, led[5]); errs++;
      end
      if (data_1_en === 1'b1 && exp_q.size() > 0) begin
        cmps++;
        if (data_1 !== exp_q[0]) begin
          $display("FAIL rr_order word%0d got %h exp %h", 12 - exp_q.size(), data_1, exp_q[0]); errs++;
        end
        void'(exp_q.pop_front());
      end
      tick();
    end
    f_valid = 0; t_valid = 0; #1;
    cmps++;
    if (exp_q.size() != 0) begin
      $display("FAIL rr_count got %0d missing exp 0", exp_q.size()); errs++;
    end
    cmps++;
    if (f_words !== (STATS ? 16'd8 : 16'd0) || t_words !== (STATS ? 16'd4 : 16'd0)) begin
      $display("FAIL rr_stats got f=%0d t=%0d exp f=%0d t=%0d", f_words, t_words,
               STATS ? 8 : 0, STATS ? 4 : 0); errs++;
    end
    go_idle();
  endtask

  task automatic test_backpressure();
    int waits = 0;
    int tw = 0;
    bit switched = 0;
    clear_inputs();
    start_t = 1; t_valid = 1; t_data = 16'h1234;
    tick();
    start_t = 0;
    cmps++;
    if ({f_words, t_words} !== 32'd0) begin
      $display("FAIL bp_stats_clear got %h exp 0", {f_words, t_words}); errs++;
    end
    for (int i = 0; i < 2; i++) begin
      cmps++;
      if (obs !== model_out()) begin
        $display("FAIL bp_pre cyc%0d got %h exp %h", i, obs, model_out()); errs++;
      end
      tick();
    end
    buffer_full = 1; #1;
    cmps++;
    if (data_1_en !== 1'b0) begin
      $display("FAIL bp_gate got %b exp 0", data_1_en); errs++;
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      start_f = (i == 0);
      buffer_full = (i < 4); #1;
      cmps++;
      if (obs !== model_out()) begin
        $display("FAIL bp_wait cyc%0d got %h exp %h", i, obs, model_out()); errs++;
      end
      if (led[3] === 1'b1 && modulo === 2'b01) waits++;
      tick();
    end
    start_f = 0;
    cmps++;
    if (waits != 5) begin
      $display("FAIL bp_wait_len got %0d exp 5", waits); errs++;
    end
    f_valid = 1;
    for (int i = 0; i < 8 && !switched; i++) begin
      #1;
      cmps++;
      if (obs !== model_out()) begin
        $display("FAIL bp_resume cyc%0d got %h exp %h", i, obs, model_out()); errs++;
      end
      if (f_en === 1'b1) switched = 1;
      else if (data_1_en === 1'b1) tw++;
      if (!switched) tick();
    end
    cmps++;
    if (!switched || tw != 2) begin
      $display("FAIL bp_rest got switched=%0d t_writes=%0d exp 1/2", switched, tw); errs++;
    end
    go_idle();
  endtask

  task automatic test_stop_drain();
    clear_inputs();
    start_f = 1; f_valid = 1;
    tick();
    start_f = 0; buffer_full = 1;
    tick();
    stop = 1;
    tick();
    stop = 0;
    for (int i = 0; i < 6; i++) begin
      start_f = (i == 0);
      buffer_empty = (i >= 4);
      data_2_valid = (i == 4); #1;
      cmps++;
      if (obs !== model_out() || led[4] !== 1'b1) begin
        $display("FAIL drain cyc%0d got %h exp %h", i, obs, model_out()); errs++;
      end
      tick();
    end
    start_f = 0;
    cmps++;
    if (led !== 6'b000001 || modulo !== 2'b00) begin
      $display("FAIL drain_exit got led=%b mod=%b exp 000001/00", led, modulo); errs++;
    end
    buffer_full = 0; start_t = 1; t_valid = 1; f_valid = 1;
    tick();
    start_t = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      cmps++;
      if (f_en !== 1'b0 || t_en !== 1'b1 || obs !== model_out()) begin
        $display("FAIL drain_req_clear cyc%0d got %h exp %h", i, obs, model_out()); errs++;
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 499) != 0);
      start_f      = ($urandom_range(0, 99) < 5);
      start_t      = ($urandom_range(0, 99) < 5);
      stop         = ($urandom_range(0, 99) < 2);
      buffer_full  = ($urandom_range(0, 99) < 20);
      buffer_empty = ($urandom_range(0, 99) < 50);
      data_2_valid = ($urandom_range(0, 99) < 30);
      f_valid      = ($urandom_range(0, 99) < 70);
      t_valid      = ($urandom_range(0, 99) < 70);
      f_data       = WIDTH'($urandom);
      t_data       = WIDTH'($urandom);
      #1;
      cmps++;
      if (obs !== model_out()) begin
        $display("FAIL random cyc%0d got %h exp %h", i, obs, model_out()); errs++;
      end
      cmps++;
      if (f_words !== 16'(m_fw) || t_words !== 16'(m_tw)) begin
        $display("FAIL random_stats cyc%0d got f=%0d t=%0d exp f=%0d t=%0d",
                 i, f_words, t_words, m_fw, m_tw); errs++;
      end
      tick();
    end
    rst = 1;
    go_idle();
  endtask

  initial begin
    model_reset();
    rst = 0;
    clear_inputs();
    @(negedge clk);
    #1;
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_stop_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
